// File: rtl/count_capture_fifo_pkg.sv
// Shared constants and helpers for the count capture FIFO slice.
// The all-ones macro is visible to every file compiled after this one.
`ifndef CCF_ALL_ONES
`define CCF_ALL_ONES(bus) (&(bus))
`endif

package count_capture_fifo_pkg;

    // A head is handed over when valid and ready are both high at the same edge.
    localparam logic HS_VALID = 1'b1;
    localparam logic HS_READY = 1'b1;

    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_SAT = '1;

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_ctl_t;

endpackage

// File: rtl/count_capture_fifo_sync_fifo.sv
// Small synchronous FIFO with an explicit level count. While empty, the
// slot that was popped last is presented, so rdata holds its final value.
module sync_fifo #(
    parameter int Width = 5,
    parameter int Depth = 4,
    parameter int AddrW = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic [AddrW:0]   level,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wptr, rptr, last_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    assign last_ptr = rptr - 1'b1;
    assign full     = (level == (AddrW+1)'(Depth));
    assign empty    = (level == '0);
    assign rdata    = empty ? mem[last_ptr] : mem[rptr];

endmodule

// File: rtl/count_capture_fifo.sv
// Captures the upstream count into a FIFO on a strobe, counts dropped
// captures and flags counter wrap-around (all-ones -> zero).
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int Size  = 5,
    parameter int Depth = 4,
    parameter int AddrW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [Size-1:0]   count_in,
    input  logic              capture,
    output logic [Size-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AddrW:0]    level,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              wrap
);

    fifo_ctl_t       ctl;
    logic            full, empty;
    logic [Size-1:0] prev;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a capture.
    always_comb begin
        ctl      = '0;
        ctl.pop  = (out_ready == HS_READY) && (out_valid == HS_VALID);
        ctl.push = capture && (!full || ctl.pop);
        ctl.drop = capture && full && !ctl.pop;
    end

    sync_fifo #(
        .Width(Size),
        .Depth(Depth),
        .AddrW(AddrW)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (ctl.push),
        .pop  (ctl.pop),
        .wdata(count_in),
        .rdata(out_data),
        .level(level),
        .full (full),
        .empty(empty)
    );

    assign out_valid = !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            prev       <= '0;
            wrap       <= 1'b0;
        end else begin
            prev <= count_in;
            wrap <= `CCF_ALL_ONES(prev) && (count_in == '0);
            // A drop in the same cycle as a clear keeps the flag set.
            if (ctl.drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_SAT) drop_count <= drop_count + 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: directed vector table, saturation sequence,
// then randomized traffic against a queue-based reference model.
module tb_count_capture_fifo;

    localparam int SIZE  = 5;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            capture = 1'b0;
    logic            out_ready = 1'b0;
    logic            clear_overflow = 1'b0;
    logic [SIZE-1:0] count_in = '0;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            overflow;
    logic            wrap;
    logic [AW:0]     level;
    logic [7:0]      drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    count_capture_fifo #(.Size(SIZE), .Depth(DEPTH), .AddrW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .count_in      (count_in),
        .capture       (capture),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .level         (level),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .drop_count    (drop_count),
        .wrap          (wrap)
    );

    // Reference model: plain queue plus the flag/counter rules.
    int q[$];
    int m_last  = 0;
    int m_prev  = 0;
    int m_drops = 0;
    bit m_ovf   = 0;
    bit m_wrap  = 0;

    function automatic void model(bit r, bit c, int cnt, bit rd, bit cl);
        bit drop;
        if (r) begin
            q.delete();
            m_last = 0; m_prev = 0; m_drops = 0; m_ovf = 0; m_wrap = 0;
            return;
        end
        m_wrap = (m_prev == (1 << SIZE) - 1) && (cnt == 0);
        m_prev = cnt;
        if (rd && q.size() > 0) m_last = q.pop_front();
        drop = 0;
        if (c) begin
            if (q.size() < DEPTH) q.push_back(cnt);
            else drop = 1;
        end
        if (drop) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
        end else if (cl) begin
            m_ovf = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit c, input int cnt, input bit rd, input bit cl);
        int v;
        v = cnt & ((1 << SIZE) - 1);
        @(negedge clock);
        reset = r; capture = c; count_in = v[SIZE-1:0]; out_ready = rd; clear_overflow = cl;
        @(posedge clock);
        model(r, c, v, rd, cl);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid),  32'(q.size() > 0));
        chk({tag, ".data"},  32'(out_data),   (q.size() > 0) ? q[0] : m_last);
        chk({tag, ".level"}, 32'(level),      q.size());
        chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".drops"}, 32'(drop_count), m_drops);
        chk({tag, ".wrap"},  32'(wrap),       32'(m_wrap));
    endtask

    typedef struct {
        bit r, c; int cnt; bit rd, cl;
        bit ev; int ed; int el; bit eo; int edc; bit ew;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input bit r, input bit c, input int cnt, input bit rd, input bit cl,
                     input bit ev, input int ed, input int el, input bit eo, input int edc, input bit ew);
        vec_t e;
        e.r = r; e.c = c; e.cnt = cnt; e.rd = rd; e.cl = cl;
        e.ev = ev; e.ed = ed; e.el = el; e.eo = eo; e.edc = edc; e.ew = ew;
        tbl.push_back(e);
    endtask

    initial begin
        int cnt;
        //   r c cnt rd cl   vld data lvl ovf drops wrap
        v(1,0, 0, 0,0,  0, 0, 0, 0, 0, 0);   // reset
        for (int i = 0; i < 3; i++) v(0,0, 0, 0,0,  0, 0, 0, 0, 0, 0);
        v(0,1, 7, 0,0,  1, 7, 1, 0, 0, 0);   // single capture
        for (int i = 0; i < 5; i++) v(0,0, 7, 0,0,  1, 7, 1, 0, 0, 0);
        v(0,0, 7, 1,0,  0, 7, 0, 0, 0, 0);   // one pop, data held
        v(0,1, 3, 0,0,  1, 3, 1, 0, 0, 0);   // fill and overflow
        v(0,1, 4, 0,0,  1, 3, 2, 0, 0, 0);
        v(0,1, 5, 0,0,  1, 3, 3, 0, 0, 0);
        v(0,1, 6, 0,0,  1, 3, 4, 0, 0, 0);
        v(0,1, 7, 0,0,  1, 3, 4, 1, 1, 0);
        v(0,1, 8, 0,0,  1, 3, 4, 1, 2, 0);
        v(0,1,20, 1,0,  1, 4, 4, 1, 2, 0);   // push+pop while full
        v(0,0,20, 1,0,  1, 5, 3, 1, 2, 0);
        v(0,0,20, 1,0,  1, 6, 2, 1, 2, 0);
        v(0,0,20, 1,0,  1,20, 1, 1, 2, 0);
        v(0,0,20, 1,0,  0,20, 0, 1, 2, 0);
        v(0,0,20, 1,1,  0,20, 0, 0, 2, 0);   // clear keeps drop_count
        v(0,0,30, 0,0,  0,20, 0, 0, 2, 0);   // wrap
        v(0,0,31, 0,0,  0,20, 0, 0, 2, 0);
        v(0,0, 0, 0,0,  0,20, 0, 0, 2, 1);
        v(0,0, 1, 0,0,  0,20, 0, 0, 2, 0);
        v(0,0,17, 0,0,  0,20, 0, 0, 2, 0);   // upstream reset, no wrap
        v(0,0, 0, 0,0,  0,20, 0, 0, 2, 0);
        v(0,1, 5, 0,0,  1, 5, 1, 0, 2, 0);   // mid-stream reset
        v(0,1, 6, 0,0,  1, 5, 2, 0, 2, 0);
        v(1,1, 9, 1,0,  0, 0, 0, 0, 0, 0);
        v(0,1, 1, 0,0,  1, 1, 1, 0, 0, 0);
        v(0,1, 2, 0,0,  1, 1, 2, 0, 0, 0);
        v(0,1, 3, 0,0,  1, 1, 3, 0, 0, 0);
        v(0,1, 4, 0,0,  1, 1, 4, 0, 0, 0);
        v(0,1, 5, 0,1,  1, 1, 4, 1, 1, 0);   // drop beats clear
        v(0,0, 5, 0,1,  1, 1, 4, 0, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].cnt, tbl[i].rd, tbl[i].cl);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid),  32'(tbl[i].ev));
            chk($sformatf("vec%0d.data", i),  32'(out_data),   tbl[i].ed);
            chk($sformatf("vec%0d.level", i), 32'(level),      tbl[i].el);
            chk($sformatf("vec%0d.ovf", i),   32'(overflow),   32'(tbl[i].eo));
            chk($sformatf("vec%0d.drops", i), 32'(drop_count), tbl[i].edc);
            chk($sformatf("vec%0d.wrap", i),  32'(wrap),       32'(tbl[i].ew));
        end

        // Drop counter saturation.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 10 + i, 0, 0);
        for (int i = 0; i < 260; i++) step(0, 1, 3, 0, 0);
        chk("sat.drops", 32'(drop_count), 255);
        chk("sat.ovf",   32'(overflow),   1);
        chk("sat.level", 32'(level),      4);
        chk("sat.data",  32'(out_data),   10);
        step(0, 0, 3, 0, 1);
        chk("sat.clr_ovf",   32'(overflow),   0);
        chk("sat.clr_drops", 32'(drop_count), 255);

        // Randomized traffic vs. model.
        step(1, 0, 0, 0, 0);
        chk_model("rnd_rst");
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) != 0) cnt = (cnt + 1) % 32;
            else if ($urandom_range(1) != 0) cnt = 0;
            else cnt = $urandom_range(31);
            step($urandom_range(63) == 0, $urandom_range(1) == 1, cnt,
                 $urandom_range(2) == 0, $urandom_range(7) == 0);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
